// File: rtl/icache_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : icache_ctrl_pkg
// Description : Shared constants, FSM encoding and address-field helpers for
//               the direct-mapped instruction cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package icache_ctrl_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_INDEX_W    = 6;
    localparam int DEF_OFFSET_W   = 2;
    localparam int DEF_CNT_W      = 16;

    localparam int TAG_W          = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int LINES          = 1 << DEF_INDEX_W;
    localparam int WORDS_PER_LINE = 1 << DEF_OFFSET_W;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Extract a width-bit field starting at bit lsb of a word address.
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int          lsb,
                                               input int          width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (addr >> lsb) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
//------------------------------------------------------------------------------
// Module      : icache_array
// Description : Tag, valid and data storage with combinational read, word
//               write, line-valid set and global invalidate.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_array
    import icache_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TAG_BITS = TAG_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int N_LINES  = LINES,
    parameter int N_WORDS  = WORDS_PER_LINE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  i_rd_index,
    input  logic [OFFSET_W-1:0] i_rd_offset,
    output logic                o_rd_valid,
    output logic [TAG_BITS-1:0] o_rd_tag,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_wr_en,
    input  logic [INDEX_W-1:0]  i_wr_index,
    input  logic [OFFSET_W-1:0] i_wr_offset,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_set_valid,
    input  logic [TAG_BITS-1:0] i_set_tag,
    input  logic                i_inv
);

    logic [DATA_W-1:0]   r_data [0:N_LINES*N_WORDS-1];
    logic [TAG_BITS-1:0] r_tag  [0:N_LINES-1];
    logic [N_LINES-1:0]  r_valid;

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];

    // A line-valid set in the same cycle as an invalidate survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_inv) begin
                r_valid <= '0;
            end
            if (i_set_valid) begin
                r_valid[i_wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
        end
        if (i_set_valid) begin
            r_tag[i_wr_index] <= i_set_tag;
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache_ctrl.sv
//------------------------------------------------------------------------------
// Module      : icache_ctrl
// Description : Direct-mapped read-only instruction cache controller with
//               word-serial line refill and saturating miss counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IC_Address,
    output logic              IC_stall,
    output logic [DATA_W-1:0] Instruction,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              inv,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int c_TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_t              r_state;
    logic [OFFSET_W-1:0] r_word;
    logic [c_TAG_W-1:0]  r_miss_tag;
    logic [INDEX_W-1:0]  r_miss_index;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic                r_mem_read;
    logic [ADDR_W-1:0]   r_mem_addr;

    logic [c_TAG_W-1:0]  w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_rd_valid;
    logic [c_TAG_W-1:0]  w_rd_tag;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_tag_hit;
    logic                w_hit;
    logic                w_wr_en;
    logic                w_set_valid;

    assign w_tag    = c_TAG_W'(addr_field(32'(IC_Address), INDEX_W + OFFSET_W, c_TAG_W));
    assign w_index  = INDEX_W'(addr_field(32'(IC_Address), OFFSET_W, INDEX_W));
    assign w_offset = OFFSET_W'(addr_field(32'(IC_Address), 0, OFFSET_W));

    assign w_tag_hit = w_rd_valid && (w_rd_tag == w_tag);
    assign w_hit     = !rst && (r_state == LOOKUP) && w_tag_hit;

    // A reset sampled on the same edge aborts the refill without writing.
    assign w_wr_en     = !rst && (r_state == REFILL) && mem_ready;
    assign w_set_valid = w_wr_en && (&r_word);

    icache_array #(
        .DATA_W   (DATA_W),
        .TAG_BITS (c_TAG_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .N_LINES  (1 << INDEX_W),
        .N_WORDS  (1 << OFFSET_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_index),
        .i_rd_offset (w_offset),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (r_miss_index),
        .i_wr_offset (r_word),
        .i_wr_data   (mem_rdata),
        .i_set_valid (w_set_valid),
        .i_set_tag   (r_miss_tag),
        .i_inv       (inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOOKUP;
            r_word     <= '0;
            r_miss_cnt <= '0;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                LOOKUP: begin
                    if (!w_tag_hit) begin
                        r_miss_tag   <= w_tag;
                        r_miss_index <= w_index;
                        r_mem_addr   <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        r_mem_read   <= 1'b1;
                        r_word       <= '0;
                        if (r_miss_cnt != {CNT_W{1'b1}}) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                        r_state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        r_word     <= r_word + OFFSET_W'(1);
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        if (&r_word) begin
                            r_mem_read <= 1'b0;
                            r_state    <= LOOKUP;
                        end
                    end
                end
                default: r_state <= LOOKUP;
            endcase
        end
    end

    assign IC_stall    = !w_hit;
    assign Instruction = w_hit ? w_rd_data : '0;
    assign mem_read    = r_mem_read;
    assign mem_addr    = r_mem_addr;
    assign miss_cnt    = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_icache_ctrl
// Description : Self-checking bench for icache_ctrl: directed vector table,
//               reset/invalidate sequences and randomized model comparison.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IC_Address;
    logic        IC_stall;
    logic [31:0] Instruction;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        inv;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Backing memory: every word holds 0xA0 plus its own address.
    assign mem_rdata = 32'hA0 + 32'(mem_addr);

    icache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .IC_Address  (IC_Address),
        .IC_stall    (IC_stall),
        .Instruction (Instruction),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .inv         (inv),
        .miss_cnt    (miss_cnt)
    );

    typedef struct {
        logic [15:0] addr;
        bit          miss;
        logic [31:0] instr;
        logic [15:0] cnt;
        int          mode;
        int          inv_cyc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One fetch: present addr, check the lookup, then service any refill.
    // mode 0: ready every cycle, 1: every 3rd cycle, 2: random.
    task automatic access(input logic [15:0] addr, input bit exp_miss,
                          input logic [31:0] exp_instr, input logic [15:0] exp_cnt,
                          input int mode, input int inv_cyc, input bit lookup_inv);
        int          cyc;
        int          words;
        int          last_pulse;
        bit          rdy;
        logic [15:0] base;
        base = addr & 16'hFFFC;
        @(posedge clk); #1;
        rst        = 1'b0;
        IC_Address = addr;
        inv        = lookup_inv;
        mem_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("lookup_stall", 32'(IC_stall), 32'(exp_miss));
        if (!exp_miss) begin
            chk("hit_instr", Instruction, exp_instr);
            chk("hit_mem_read", 32'(mem_read), 32'd0);
            chk("hit_miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
            return;
        end
        chk("miss_instr_zero", Instruction, 32'd0);
        cyc = 0;
        words = 0;
        last_pulse = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            mem_ready = rdy;
            inv       = (cyc == inv_cyc);
            @(negedge clk);
            if (!IC_stall) break;
            if (cyc > 200) begin
                chk("refill_timeout", 32'(cyc), 32'd200);
                break;
            end
            if (rdy) begin
                chk("refill_addr", 32'(mem_addr), 32'(base) + 32'(words));
                chk("refill_mem_read", 32'(mem_read), 32'd1);
                words++;
                last_pulse = cyc;
            end
        end
        mem_ready = 1'b0;
        chk("refill_words", 32'(words), 32'd4);
        chk("refill_latency", 32'(cyc), 32'(last_pulse + 1));
        chk("refill_instr", Instruction, exp_instr);
        chk("refill_done_read", 32'(mem_read), 32'd0);
        chk("refill_miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          present [int];
        int          del_q [$];
        int          mcnt;
        logic [15:0] a;
        int          line;
        bit          miss;
        bit          linv;
        int          icyc;
        int          mode;

        vecs[0]  = '{16'h0000, 1'b1, 32'h0A0, 16'd1, 0, 0};
        vecs[1]  = '{16'h0001, 1'b0, 32'h0A1, 16'd1, 0, 0};
        vecs[2]  = '{16'h0002, 1'b0, 32'h0A2, 16'd1, 0, 0};
        vecs[3]  = '{16'h0003, 1'b0, 32'h0A3, 16'd1, 0, 0};
        vecs[4]  = '{16'h0100, 1'b1, 32'h1A0, 16'd2, 0, 0};
        vecs[5]  = '{16'h0000, 1'b1, 32'h0A0, 16'd3, 0, 0};
        vecs[6]  = '{16'h0104, 1'b1, 32'h1A4, 16'd4, 1, 0};
        vecs[7]  = '{16'h0107, 1'b0, 32'h1A7, 16'd4, 0, 0};
        vecs[8]  = '{16'h0010, 1'b1, 32'h0B0, 16'd5, 0, 2};
        vecs[9]  = '{16'h0013, 1'b0, 32'h0B3, 16'd5, 0, 0};
        vecs[10] = '{16'h0000, 1'b1, 32'h0A0, 16'd6, 0, 0};
        vecs[11] = '{16'h0105, 1'b1, 32'h1A5, 16'd7, 2, 0};

        rst        = 1'b1;
        IC_Address = '0;
        mem_ready  = 1'b0;
        inv        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(IC_stall), 32'd1);
        chk("reset_instr", Instruction, 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_miss_cnt", 32'(miss_cnt), 32'd0);

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].addr, vecs[i].miss, vecs[i].instr, vecs[i].cnt,
                   vecs[i].mode, vecs[i].inv_cyc, 1'b0);
        end

        // Invalidate on a hitting lookup: this cycle hits, the next misses.
        access(16'h0105, 1'b0, 32'h1A5, 16'd7, 0, 0, 1'b1);
        access(16'h0105, 1'b1, 32'h1A5, 16'd8, 0, 0, 1'b0);

        // Reset two words into a refill.
        @(posedge clk); #1;
        IC_Address = 16'h0200;
        inv        = 1'b0;
        mem_ready  = 1'b1;
        @(negedge clk);
        chk("rst_seq_miss", 32'(IC_stall), 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            mem_ready = 1'b1;
            @(negedge clk);
            chk("rst_seq_addr", 32'(mem_addr), 32'h200 + 32'(c));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_abort_read", 32'(mem_read), 32'd0);
        chk("rst_abort_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_abort_stall", 32'(IC_stall), 32'd1);
        chk("rst_abort_instr", Instruction, 32'd0);
        access(16'h0200, 1'b1, 32'h2A0, 16'd1, 0, 0, 1'b0);

        // Randomized phase against a resident-line model, from a fresh reset.
        rst  = 1'b1;
        mcnt = 0;
        for (int it = 0; it < 120; it++) begin
            a    = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2)
                       | $urandom_range(0, 3));
            line = int'(a) >> 2;
            miss = !present.exists(line);
            linv = ($urandom_range(0, 9) == 0);
            icyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            mode = int'($urandom_range(0, 2));
            if (miss) mcnt++;
            access(a, miss, 32'hA0 + 32'(a), 16'(mcnt), mode, miss ? icyc : 0, linv);
            if (linv || (miss && icyc != 0)) present.delete();
            if (miss) begin
                del_q.delete();
                foreach (present[k]) if ((k % 64) == (line % 64)) del_q.push_back(k);
                foreach (del_q[j]) present.delete(del_q[j]);
                present[line] = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
